// File: rtl/alu_param_pkg.sv
// Shared types and constants for the parameterised ALU.
// The optional input register is enabled with the ALU_INPUT_REG_EN macro (see alu_param.sv).
package alu_param_pkg;

    // Opcode map; 10-15 are unused and produce a zero result
    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_INC = 4'd3,
        OP_DEC = 4'd4,
        OP_NOT = 4'd5,
        OP_SUB = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } alu_op_t;

    // Bit positions inside ALUflags
    localparam int Z_IDX = 1;
    localparam int C_IDX = 0;

    // Flag value held while in reset: zero result, no carry
    localparam logic [1:0] FLAGS_RESET = 2'b10;

    // Shifter direction encoding
    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

endpackage

// File: rtl/alu_param_if.sv
// Operand/opcode/result bundle of the ALU. The master drives operands and
// opcode and observes result and flags; the slave is the ALU itself.
interface alu_param_if #(
    parameter int n = 4
);
    logic [n-1:0] ALUA;
    logic [n-1:0] ALUB;
    logic [3:0]   ALUcontrol;
    logic         ALUFLAGin;
    logic [n-1:0] ALUresult;
    logic [1:0]   ALUflags;

    modport master (
        output ALUA,
        output ALUB,
        output ALUcontrol,
        output ALUFLAGin,
        input  ALUresult,
        input  ALUflags
    );

    modport slave (
        input  ALUA,
        input  ALUB,
        input  ALUcontrol,
        input  ALUFLAGin,
        output ALUresult,
        output ALUflags
    );
endinterface

// File: rtl/alu_param_shifter.sv
// Combinational logical shifter with programmable fill bit.
// Shift amounts above n saturate to an all-fill result; last bit out is
// reported for 1..n, is zero for no shift and equals the fill beyond n.
module alu_param_shifter
    import alu_param_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] s,
    input  logic         fill,
    input  logic         dir,
    output logic [n-1:0] result,
    output logic         last
);

    // n always fits in n bits for n >= 2, so it can be compared to s directly
    localparam logic [n-1:0] N_VAL = n'(n);

    logic [2*n-1:0] left_ext;
    logic [2*n-1:0] right_ext;

    // Shift a double-width vector so the fill bits stream into the vacated positions
    always_comb begin
        left_ext  = {a, {n{fill}}} << s;
        right_ext = {{n{fill}}, a} >> s;
        result    = a;
        last      = 1'b0;
        if (s == '0) begin
            result = a;
            last   = 1'b0;
        end else if (s > N_VAL) begin
            result = {n{fill}};
            last   = fill;
        end else if (dir == SH_LEFT) begin
            result = left_ext[2*n-1:n];
            for (int i = 0; i < n; i++) begin
                if (n'(i) == (N_VAL - s)) begin
                    last = a[i];
                end
            end
        end else begin
            result = right_ext[n-1:0];
            for (int i = 0; i < n; i++) begin
                if (n'(i + 1) == s) begin
                    last = a[i];
                end
            end
        end
    end

endmodule

// File: rtl/alu_param.sv
// Parameterised n-bit ALU: ten opcodes, registered result and Z/C flags.
// The flag input acts as carry-in, borrow-in, operand select or shift fill.
// Define ALU_INPUT_REG_EN to register the inputs first (latency 2 instead of 1).
module alu_param
    import alu_param_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_param_if.slave   bus
);

    logic [n-1:0] a_p0;
    logic [n-1:0] b_p0;
    logic [3:0]   op_p0;
    logic         f_p0;

`ifdef ALU_INPUT_REG_EN
    logic [n-1:0] a_p0_d, a_p0_q;
    logic [n-1:0] b_p0_d, b_p0_q;
    logic [3:0]   op_p0_d, op_p0_q;
    logic         f_p0_d, f_p0_q;

    // Next value of the input register is simply the current bus inputs
    always_comb begin
        a_p0_d  = bus.ALUA;
        b_p0_d  = bus.ALUB;
        op_p0_d = bus.ALUcontrol;
        f_p0_d  = bus.ALUFLAGin;
    end

    // Input register stage, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0_q  <= '0;
            b_p0_q  <= '0;
            op_p0_q <= '0;
            f_p0_q  <= 1'b0;
        end else begin
            a_p0_q  <= a_p0_d;
            b_p0_q  <= b_p0_d;
            op_p0_q <= op_p0_d;
            f_p0_q  <= f_p0_d;
        end
    end

    assign a_p0  = a_p0_q;
    assign b_p0  = b_p0_q;
    assign op_p0 = op_p0_q;
    assign f_p0  = f_p0_q;
`else
    assign a_p0  = bus.ALUA;
    assign b_p0  = bus.ALUB;
    assign op_p0 = bus.ALUcontrol;
    assign f_p0  = bus.ALUFLAGin;
`endif

    logic [n-1:0] opnd_sel;
    logic [n:0]   sum_w;
    logic [n:0]   diff_w;
    logic [n:0]   inc_w;
    logic [n:0]   dec_w;
    logic [n-1:0] sh_result;
    logic         sh_last;
    logic         sh_dir;

    logic [n-1:0] result_p1_d, result_p1_q;
    logic [1:0]   flags_p1_d, flags_p1_q;
    logic         c_p1;

    assign sh_dir = (op_p0 == OP_SHR) ? SH_RIGHT : SH_LEFT;

    alu_param_shifter #(
        .n (n)
    ) u_shifter (
        .a      (a_p0),
        .s      (b_p0),
        .fill   (f_p0),
        .dir    (sh_dir),
        .result (sh_result),
        .last   (sh_last)
    );

    // (n+1)-bit arithmetic: bit n is carry for add/inc and borrow for sub/dec
    always_comb begin
        opnd_sel = f_p0 ? b_p0 : a_p0;
        sum_w    = {1'b0, a_p0} + {1'b0, b_p0} + (n+1)'(f_p0);
        diff_w   = {1'b0, a_p0} - {1'b0, b_p0} - (n+1)'(f_p0);
        inc_w    = {1'b0, opnd_sel} + (n+1)'(1);
        dec_w    = {1'b0, opnd_sel} - (n+1)'(1);
    end

    // Opcode decode: select result and carry, derive Z from the final result
    always_comb begin
        result_p1_d = '0;
        c_p1        = 1'b0;
        case (op_p0)
            OP_AND: result_p1_d = a_p0 & b_p0;
            OP_OR:  result_p1_d = a_p0 | b_p0;
            OP_ADD: begin
                result_p1_d = sum_w[n-1:0];
                c_p1        = sum_w[n];
            end
            OP_INC: begin
                result_p1_d = inc_w[n-1:0];
                c_p1        = inc_w[n];
            end
            OP_DEC: begin
                result_p1_d = dec_w[n-1:0];
                c_p1        = dec_w[n];
            end
            OP_NOT: result_p1_d = ~opnd_sel;
            OP_SUB: begin
                result_p1_d = diff_w[n-1:0];
                c_p1        = diff_w[n];
            end
            OP_XOR: result_p1_d = a_p0 ^ b_p0;
            OP_SHL, OP_SHR: begin
                result_p1_d = sh_result;
                c_p1        = sh_last;
            end
            default: begin
                result_p1_d = '0;
                c_p1        = 1'b0;
            end
        endcase
        flags_p1_d        = '0;
        flags_p1_d[Z_IDX] = (result_p1_d == '0);
        flags_p1_d[C_IDX] = c_p1;
    end

    // Output register stage; reset forces a zero result with Z set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1_q <= '0;
            flags_p1_q  <= FLAGS_RESET;
        end else begin
            result_p1_q <= result_p1_d;
            flags_p1_q  <= flags_p1_d;
        end
    end

    assign bus.ALUresult = result_p1_q;
    assign bus.ALUflags  = flags_p1_q;

endmodule

// File: tb/tb_alu_param.sv
// Scoreboard bench for alu_param with n=4: directed cases, exhaustive sweep
// and random ops. Build with or without ALU_INPUT_REG_EN.
module tb_alu_param;

    localparam int N = 4;
`ifdef ALU_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [3:0] res;
        logic [1:0] flg;
        int         rdy;
        string      nm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    alu_param_if #(.n(N)) bus ();

    alu_param #(.n(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the opcode rules, returns {Z, C, result}
    function automatic logic [5:0] model(int op, int a, int b, int f);
        int x, r, c, s;
        x = (f != 0) ? b : a;
        r = 0;
        c = 0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: begin s = a + b + f; r = s % 16; c = (s >= 16) ? 1 : 0; end
            3: begin r = (x + 1) % 16; c = (x == 15) ? 1 : 0; end
            4: begin r = (x + 15) % 16; c = (x == 0) ? 1 : 0; end
            5: r = 15 - x;
            6: begin c = (a < b + f) ? 1 : 0; r = (a - b - f + 32) % 16; end
            7: r = a ^ b;
            8: begin
                if (b == 0) r = a;
                else if (b > N) begin r = f ? 15 : 0; c = f; end
                else begin
                    r = ((a << b) & 15) | (f ? ((1 << b) - 1) : 0);
                    c = (a >> (N - b)) & 1;
                end
            end
            9: begin
                if (b == 0) r = a;
                else if (b > N) begin r = f ? 15 : 0; c = f; end
                else begin
                    r = (a >> b) | (f ? ((15 << (N - b)) & 15) : 0);
                    c = (a >> (b - 1)) & 1;
                end
            end
            default: begin r = 0; c = 0; end
        endcase
        return {(r == 0) ? 1'b1 : 1'b0, c[0], r[3:0]};
    endfunction

    task automatic cmp(input string nm, input logic [3:0] gr, input logic [1:0] gf,
                       input logic [3:0] er, input logic [1:0] ef);
        n_cmp++;
        if (gr !== er || gf !== ef) begin
            n_err++;
            $display("FAIL %s: got result=%b flags=%b, expected result=%b flags=%b",
                     nm, gr, gf, er, ef);
        end
    endtask

    task automatic drive(input int op, input int a, input int b, input int f);
        logic [3:0] ov, av, bv;
        ov = op[3:0];
        av = a[3:0];
        bv = b[3:0];
        bus.ALUcontrol = ov;
        bus.ALUA       = av;
        bus.ALUB       = bv;
        bus.ALUFLAGin  = (f != 0);
    endtask

    // Issue with an explicitly stated expectation
    task automatic issue_exp(input string nm, input int op, input int a, input int b, input int f,
                             input logic [3:0] er, input logic [1:0] ef);
        exp_t e;
        @(negedge clk);
        drive(op, a, b, f);
        e.res = er;
        e.flg = ef;
        e.rdy = cyc + LAT;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    // Issue with the expectation taken from the reference model
    task automatic issue(input string nm, input int op, input int a, input int b, input int f);
        logic [5:0] m;
        m = model(op, a, b, f);
        issue_exp(nm, op, a, b, f, m[3:0], m[5:4]);
    endtask

    // Monitor: after each rising edge, retire every expectation due this cycle
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst_n) begin
                while (sb.size() > 0 && sb[0].rdy <= cyc) begin
                    e = sb.pop_front();
                    cmp(e.nm, bus.ALUresult, bus.ALUflags, e.res, e.flg);
                end
            end
        end
    end

    initial begin : driver
        cyc   = 0;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        drive(0, 0, 0, 0);

        // Asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1 cmp("reset_async", bus.ALUresult, bus.ALUflags, 4'b0000, 2'b10);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue_exp("and_after_reset", 0, 4'b1100, 4'b1010, 0, 4'b1000, 2'b00);
        issue_exp("add_wrap",        2, 4'b1111, 4'b0001, 0, 4'b0000, 2'b11);
        issue_exp("add_cin",         2, 4'b0111, 4'b1000, 1, 4'b0000, 2'b11);
        issue_exp("sub_borrow",      6, 4'b0011, 4'b0101, 0, 4'b1110, 2'b01);
        issue_exp("sub_bin_zero",    6, 4'b0101, 4'b0100, 1, 4'b0000, 2'b10);
        issue_exp("inc_sel_b",       3, 4'b0010, 4'b0111, 1, 4'b1000, 2'b00);
        issue_exp("dec_zero",        4, 4'b0000, 4'b0000, 0, 4'b1111, 2'b01);
        issue_exp("not_sel_b",       5, 4'b0000, 4'b1111, 1, 4'b0000, 2'b10);
        issue_exp("shl_fill",        8, 4'b1011, 2,       1, 4'b1111, 2'b00);
        issue_exp("shr_last",        9, 4'b1011, 1,       0, 4'b0101, 2'b01);
        issue_exp("shr_over",        9, 4'b1011, 6,       1, 4'b1111, 2'b01);
        for (int op = 10; op < 16; op++)
            issue_exp("unused_op", op, 4'b1111, 4'b1111, 1, 4'b0000, 2'b10);
        issue_exp("or_ones", 1, 4'b1010, 4'b0101, 0, 4'b1111, 2'b00);

        // Reset mid-run: output clears immediately, pending results are dropped
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1 cmp("reset_midrun", bus.ALUresult, bus.ALUflags, 4'b0000, 2'b10);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int op = 0; op < 16; op++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    for (int f = 0; f < 2; f++)
                        issue("sweep", op, a, b, f);

        for (int i = 0; i < 500; i++)
            issue("random", $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 1));

        repeat (LAT + 3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d outstanding results, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
